mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_pkg.sv | 44 ++++
 rtl/mem_lsu_load_extend.sv | 26 ++
 rtl/mem_lsu.sv | 127 ++++++++++++
 tb/tb_mem_lsu.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the load/store unit: access sizes, FSM states,
// byte-enable patterns and the legality check applied when a request is accepted.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } lsu_state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Size code 11 and any access not naturally aligned to its size are rejected.
  function automatic logic req_bad(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = offset[0];
      SZ_W:    bad = |offset;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] base_be(input logic [1:0] size);
    logic [3:0] be;
    case (size)
      SZ_B:    be = BE_BYTE;
      SZ_H:    be = BE_HALF;
      SZ_W:    be = BE_WORD;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_lsu_load_extend.sv
// Combinational load formatter: picks the addressed lane out of a RAM word and
// sign- or zero-extends it to 32 bits.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [31:0] lane;

  assign lane = word >> {offset, 3'b000};

  always_comb begin
    result = lane;
    case (size)
      SZ_B:    result = {{24{lane[7] & ~is_unsigned}}, lane[7:0]};
      SZ_H:    result = {{16{lane[15] & ~is_unsigned}}, lane[15:0]};
      default: result = lane;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit driving a word RAM over a shared tri-state data bus; one request in flight.
// Response pulses 3 cycles after accept (2 for errors); req_ready low while busy, no response backpressure.
module mem_lsu
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_wen,
  output logic [3:0]        mem_byte_en,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data
);

  lsu_state_e        state;
  lsu_state_e        state_nx;
  logic              accept;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [31:0]       ld_word_q;
  logic [31:0]       ext_data;
  logic [DATA_W-1:0] wdata_lane;

  assign accept = req_valid && req_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx = req_bad(req_size, req_addr[1:0]) ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: state_nx = ST_RESP;
      ST_RESP:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Outputs: the RAM bus is only active for the single ACCESS cycle.
  always_comb begin
    req_ready   = 1'b0;
    mem_wen     = 1'b0;
    mem_byte_en = 4'b0000;
    mem_addr    = '0;
    case (state)
      ST_IDLE: req_ready = 1'b1;
      ST_ACCESS: begin
        mem_wen     = we_q;
        mem_byte_en = base_be(size_q) << addr_q[1:0];
        mem_addr    = {addr_q[ADDR_W-1:2], 2'b00};
      end
      default: ;
    endcase
  end

  assign wdata_lane = wdata_q << {addr_q[1:0], 3'b000};
  assign mem_data   = mem_wen ? wdata_lane : 'z;

  // Request capture, load-word sampling and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ld_word_q <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        err_q   <= req_bad(req_size, req_addr[1:0]);
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == ST_ACCESS && !we_q) begin
        ld_word_q <= mem_data;
      end
      rsp_valid <= (state == ST_RESP);
      rsp_err   <= (state == ST_RESP) && err_q;
      if (state == ST_RESP) begin
        rsp_rdata <= (err_q || we_q) ? '0 : ext_data;
      end
    end
  end

  load_extend u_load_extend (
    .word        (ld_word_q),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .result      (ext_data)
  );

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed vector table, multi-cycle reset/back-to-back sequences,
// and random traffic checked against a byte-array reference memory.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_wen;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_addr;
  wire  [31:0] mem_data;

  always #5 clk = ~clk;

  mem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_wen      (mem_wen),
    .mem_byte_en  (mem_byte_en),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data)
  );

  function automatic logic [31:0] seed(input int i);
    return 32'(i) * 32'h9E3779B9 + 32'h01234567;
  endfunction

  // Environment RAM: 16 words, answers loads on the shared bus, idles the bus at 0.
  logic [31:0] ram [0:15];
  logic        ram_load = 1'b0;
  logic [31:0] tb_drv;

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 16; i++) ram[i] <= seed(i);
    end else if (mem_wen) begin
      for (int b = 0; b < 4; b++)
        if (mem_byte_en[b]) ram[mem_addr[5:2]][8*b +: 8] <= mem_data[8*b +: 8];
    end
  end

  assign tb_drv   = (!mem_wen && mem_byte_en != 4'b0000) ? ram[mem_addr[5:2]] : 32'h0;
  assign mem_data = mem_wen ? 32'hzzzzzzzz : tb_drv;

  // Bus monitor: with mem_wen low only the environment may drive the bus.
  int bus_viol = 0;
  int rv_total = 0;
  bit mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en && !mem_wen && mem_data !== tb_drv) bus_viol++;
    if (mon_en && rsp_valid) rv_total++;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  // Reference model: flat little-endian byte memory.
  logic [7:0] ref_mem [0:63];

  function automatic bit m_bad(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    int n;
    logic [63:0] v;
    n = 1 << sz;
    v = 64'h0;
    for (int i = 0; i < n; i++) v = v | (64'(ref_mem[int'(a[5:0]) + i]) << (8 * i));
    if (!uns && v[8*n-1]) v = v | (~64'h0 << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] be;
    be = 4'b0000;
    for (int i = 0; i < (1 << sz); i++) be[int'(a[1:0]) + i] = 1'b1;
    return be;
  endfunction

  logic [31:0] obs_rdata;
  logic        obs_err;

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input string nm);
    bit          bad;
    logic [31:0] exp_rd;
    int          to, wen_n, rv_n, rv_k;
    logic        k1_wen;
    logic [3:0]  k1_be;
    logic [31:0] k1_addr, k1_data, rd4;
    bad    = m_bad(sz, a);
    exp_rd = (bad || we) ? 32'h0 : m_load(sz, uns, a);
    to = 0; wen_n = 0; rv_n = 0; rv_k = 0;
    k1_wen = 1'b0; k1_be = 4'h0; k1_addr = 32'h0; k1_data = 32'h0; rd4 = 32'h0;
    obs_rdata = 32'h0; obs_err = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    while (!req_ready && to < 8) begin @(negedge clk); to++; end
    chk({nm, " ready"}, 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        k1_wen = mem_wen; k1_be = mem_byte_en; k1_addr = mem_addr; k1_data = mem_data;
      end
      if (mem_wen) wen_n++;
      if (rsp_valid) begin
        rv_n++;
        if (rv_k == 0) rv_k = k;
        obs_rdata = rsp_rdata; obs_err = rsp_err;
      end
      if (k == 4) rd4 = rsp_rdata;
    end
    chk({nm, " rsp_count"}, 32'(rv_n), 32'd1);
    chk({nm, " rsp_latency"}, 32'(rv_k), bad ? 32'd2 : 32'd3);
    chk({nm, " rsp_err"}, 32'(obs_err), 32'(bad));
    chk({nm, " rsp_rdata"}, obs_rdata, exp_rd);
    chk({nm, " rdata_hold"}, rd4, exp_rd);
    chk({nm, " wen_cycles"}, 32'(wen_n), (!bad && we) ? 32'd1 : 32'd0);
    if (!bad) begin
      chk({nm, " mem_addr"}, k1_addr, {a[31:2], 2'b00});
      chk({nm, " byte_en"}, 32'(k1_be), 32'(m_be(sz, a)));
      chk({nm, " wen"}, 32'(k1_wen), 32'(we));
      if (we) chk({nm, " mem_data"}, k1_data, wd << (8 * int'(a[1:0])));
    end else begin
      chk({nm, " err_no_bus"}, 32'(k1_be), 32'h0);
    end
    if (!bad && we)
      for (int i = 0; i < (1 << sz); i++) ref_mem[int'(a[5:0]) + i] = wd[8*i +: 8];
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap, rv0, wen_seen;
    logic [31:0] tmp;

    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h80017F02, 1'b0, 32'h00000000};
    tbl[1]  = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        1'b0, 32'hFFFF8001};
    tbl[2]  = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        1'b0, 32'h00008001};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h11, 32'h0,        1'b0, 32'h0000007F};
    tbl[4]  = '{1'b1, 2'd0, 1'b0, 32'h13, 32'h000000AB, 1'b0, 32'h00000000};
    tbl[5]  = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        1'b0, 32'hFFFFFFAB};
    tbl[6]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        1'b0, 32'h000000AB};
    tbl[7]  = '{1'b0, 2'd2, 1'b0, 32'h06, 32'h0,        1'b1, 32'h00000000};
    tbl[8]  = '{1'b0, 2'd1, 1'b0, 32'h01, 32'h0,        1'b1, 32'h00000000};
    tbl[9]  = '{1'b0, 2'd3, 1'b0, 32'h00, 32'h0,        1'b1, 32'h00000000};
    tbl[10] = '{1'b1, 2'd2, 1'b0, 32'h05, 32'h11223344, 1'b1, 32'h00000000};
    tbl[11] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        1'b0, 32'hAB017F02};
    tbl[12] = '{1'b0, 2'd1, 1'b0, 32'h10, 32'h0,        1'b0, 32'h00007F02};
    tbl[13] = '{1'b1, 2'd1, 1'b0, 32'h16, 32'hDEADBEEF, 1'b0, 32'h00000000};
    tbl[14] = '{1'b0, 2'd1, 1'b1, 32'h16, 32'h0,        1'b0, 32'h0000BEEF};
    tbl[15] = '{1'b0, 2'd1, 1'b0, 32'h16, 32'h0,        1'b0, 32'hFFFFBEEF};

    for (int w = 0; w < 16; w++) begin
      tmp = seed(w);
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = tmp[8*b +: 8];
    end

    // Reset state.
    rst = 1'b1; ram_load = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset rsp_err", 32'(rsp_err), 32'h0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset mem_wen", 32'(mem_wen), 32'h0);
    chk("reset byte_en", 32'(mem_byte_en), 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    rst = 1'b0; ram_load = 1'b0; mon_en = 1'b1;
    @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'h1);

    // Directed vectors.
    for (int i = 0; i < 16; i++) begin
      issue(tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].wd, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d table_err", i), 32'(obs_err), 32'(tbl[i].err));
      chk($sformatf("vec%0d table_rdata", i), obs_rdata, tbl[i].rd);
    end

    // Back-to-back: second request held valid is taken 3 cycles after the first.
    rv0 = rv_total;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
    gap = 0;
    while (!req_ready && gap < 8) begin @(negedge clk); gap++; end
    @(posedge clk);
    #1;
    req_size = 2'd1; req_unsigned = 1'b1; req_addr = 32'h12;
    gap = 0;
    @(negedge clk);
    while (!req_ready && gap < 10) begin gap++; @(negedge clk); end
    chk("b2b accept_spacing", 32'(gap + 1), 32'd3);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("b2b rsp_pulses", 32'(rv_total - rv0), 32'd2);
    chk("b2b second_rdata", rsp_rdata, m_load(2'd1, 1'b1, 32'h12));

    // Reset during the ACCESS cycle of a load discards the response.
    rv0 = rv_total;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h10;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_access in_access", 32'(mem_byte_en), 32'hF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_access req_ready", 32'(req_ready), 32'h1);
    chk("rst_access rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_access byte_en", 32'(mem_byte_en), 32'h0);
    chk("rst_access mem_addr", mem_addr, 32'h0);
    repeat (4) @(negedge clk);
    chk("rst_access no_rsp", 32'(rv_total - rv0), 32'h0);

    // Request presented together with reset is not accepted.
    rv0 = rv_total; wen_seen = 0;
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
    req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (mem_wen) wen_seen++;
    end
    chk("rst_req no_rsp", 32'(rv_total - rv0), 32'h0);
    chk("rst_req no_write", 32'(wen_seen), 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, "rst_req readback");

    // Random traffic against the reference model.
    for (int i = 0; i < 60; i++) begin
      issue(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
            32'($urandom_range(0, 63)), $urandom, $sformatf("rand%0d", i));
    end

    chk("bus_monitor violations", 32'(bus_viol), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
